mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares a single unified memory port between the instruction-fetch requester and the memory-stage (load/store) requester of the 4-stage pipeline. Round-robin arbitration, one outstanding transaction at a time. The block registers the winning command onto the memory bus and routes the response back to its owner. It also produces per-requester stall signals so the pipeline freezes until its access completes.

## Interface
- TIMEOUT_CYCLES, 255: max BUSY cycles before abort (only with `MEM_ARB_TIMEOUT_EN`); width 8 bits.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_request  in  1  fetch read request; held until if_data_valid.
- if_addr  in  32  fetch address.
- if_data_valid  out  1  fetch response strobe.
- if_rdata  out  32  fetch read data.
- if_stall  out  1  fetch must hold.
- dm_request  in  1  load/store request; held until dm_data_valid.
- dm_we_re  in  1  1 = store, 0 = load.
- dm_mask  in  4  byte enables.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_data_valid  out  1  data response strobe.
- dm_rdata  out  32  load data.
- dm_stall  out  1  memory stage must hold.
- mem_request  out  1  bus request, level.
- mem_we_re  out  1  bus write enable.
- mem_mask  out  4  bus byte enables (4'hF for fetch).
- mem_addr  out  32  bus address.
- mem_wdata  out  32  bus write data (0 for fetch).
- mem_data_valid  in  1  bus completion strobe.
- mem_rdata  in  32  bus read data.
- timeout_err  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, IF_BUSY, DM_BUSY.
- IDLE: if only one request is high, grant it. If both are high, grant the one not granted last (`last_grant` register; reset value = IF, so data wins the first tie).
- On grant: latch addr/mask/wdata/we_re into mem_* registers, set `last_grant`, enter X_BUSY.
- X_BUSY: mem_request = 1, mem_* stable. Completion is the first cycle with mem_data_valid = 1.
  - x_data_valid = 1 and x_rdata = mem_rdata, combinational, in that cycle only.
  - Next state: if the other requester's request is high, grant it directly (chain to the other BUSY state). Otherwise IDLE.
  - The completing requester's own request is ignored in the completion cycle (stale by protocol).
- Non-owner x_data_valid = 0 and x_rdata = 0 at all times.
- mem_data_valid in IDLE is ignored.
- Fetch commands: mem_we_re = 0, mem_mask = 4'hF, mem_wdata = 0.
- Stalls: if_stall = if_request & ~if_data_valid; dm_stall = dm_request & ~dm_data_valid.

## Timing
- Reset values: state IDLE, last_grant IF, all mem_* 0, timeout_err 0. Data-valid and rdata outputs are 0 while in reset.
- Request seen in IDLE at cycle T: mem_request = 1 from T+1. Memory completes at T+k (k ≥ 1). The requester sees data_valid at T+k and its stall drops in that same cycle.
- Chained grant: the other command is on the bus at T+k+1, giving zero idle cycles.
- rst asserted mid-transaction: IDLE and mem_request = 0 in the cycle after the rst edge. Any in-flight response is discarded.
- Simultaneous mem_data_valid and timeout in the same cycle: the completion wins and no error is flagged.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on grant and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without mem_data_valid, the owner receives data_valid = 1 with rdata = 0. timeout_err is set (sticky until rst) and the FSM follows the normal completion next-state rule.
- Macro undefined:
  - No counter is built. BUSY waits indefinitely.
  - timeout_err is tied to 0.

## Structure
- Package `mem_arb_pkg`: FSM state enum (IDLE, IF_BUSY, DM_BUSY), requester id constants (REQ_IF, REQ_DM), fetch mask constant 4'hF, timeout counter width.
- Sub-module `mem_arb_timeout`: counter plus expiry compare, instantiated only under `MEM_ARB_TIMEOUT_EN`.

## Test plan
- Single fetch to addr 0x0000_0010, memory replies after 3 cycles with 0xDEAD_BEEF:
  - mem_request high for cycles 1–3.
  - if_data_valid = 1 with 0xDEAD_BEEF at cycle 3.
  - if_stall low from cycle 3.
- Both request in the first cycle after reset (store, mask 4'b0011, wdata 0x1234_5678):
  - Data is granted first with mem_we_re = 1 and mem_mask = 0011.
  - The fetch is chained with zero gap and mem_mask = F.
- Continuous dual requests over 10 transactions: grants alternate DM, IF, DM, ... with no requester starved.
- rst asserted while in DM_BUSY:
  - mem_request = 0 on the next cycle.
  - A late mem_data_valid produces no dm_data_valid.
  - The following fetch is served normally.
- With `MEM_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES = 4, memory silent:
  - dm_data_valid = 1 with rdata 0 after 4 BUSY cycles.
  - timeout_err = 1 and stays high.
  - Without the macro, the bench sees the request held indefinitely.
- Spurious mem_data_valid in IDLE: no data_valid outputs, no state change.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } arb_state_t;

  localparam logic       REQ_IF     = 1'b0;
  localparam logic       REQ_DM     = 1'b1;
  localparam logic [3:0] FETCH_MASK = 4'hF;
  localparam int         TO_W       = 8;

endpackage

// File: rtl/mem_arb_timeout.sv
// BUSY-cycle watchdog for the memory-port arbiter; only present when MEM_ARB_TIMEOUT_EN is defined.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_timeout
  import mem_arb_pkg::*;
#(
  parameter logic [TO_W-1:0] LIMIT = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_busy,
  output logic o_expired
);

  logic [TO_W-1:0] r_count;

  // Saturates at LIMIT so a stuck bus never wraps the counter back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_busy && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_busy && (r_count == LIMIT);

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store, one transaction in flight.
// Optional BUSY timeout with sticky error is built only when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_request,
  input  logic [31:0] if_addr,
  output logic        if_data_valid,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        dm_request,
  input  logic        dm_we_re,
  input  logic [3:0]  dm_mask,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_data_valid,
  output logic [31:0] dm_rdata,
  output logic        dm_stall,
  output logic        mem_request,
  output logic        mem_we_re,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_data_valid,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err
);

  arb_state_t  r_state, w_state_nxt;
  logic        r_last_grant;
  logic        r_mem_we_re;
  logic [3:0]  r_mem_mask;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic        w_busy, w_expired, w_done;
  logic        w_grant_if, w_grant_dm;
  logic        w_if_done, w_dm_done;
  logic [31:0] w_rdata;

  assign w_busy = (r_state != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
  logic r_timeout_err;

  mem_arb_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_grant_if | w_grant_dm),
    .i_busy    (w_busy),
    .o_expired (w_expired)
  );

  // A real completion in the expiry cycle takes precedence and is not an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout_err <= 1'b0;
    end else if (w_expired && !mem_data_valid) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_expired        = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  assign w_done = w_busy && (mem_data_valid || w_expired);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_dm  = 1'b0;
    case (r_state)
      IDLE: begin
        if (dm_request && (!if_request || (r_last_grant == REQ_IF))) begin
          w_grant_dm = 1'b1;
        end else if (if_request) begin
          w_grant_if = 1'b1;
        end
      end
      IF_BUSY: begin
        if (w_done) begin
          if (dm_request) w_grant_dm = 1'b1;
          else            w_state_nxt = IDLE;
        end
      end
      DM_BUSY: begin
        if (w_done) begin
          if (if_request) w_grant_if = 1'b1;
          else            w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_grant_if) w_state_nxt = IF_BUSY;
    if (w_grant_dm) w_state_nxt = DM_BUSY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= REQ_IF;
      r_mem_we_re  <= 1'b0;
      r_mem_mask   <= 4'h0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_if) begin
        r_last_grant <= REQ_IF;
        r_mem_we_re  <= 1'b0;
        r_mem_mask   <= FETCH_MASK;
        r_mem_addr   <= if_addr;
        r_mem_wdata  <= 32'h0;
      end else if (w_grant_dm) begin
        r_last_grant <= REQ_DM;
        r_mem_we_re  <= dm_we_re;
        r_mem_mask   <= dm_mask;
        r_mem_addr   <= dm_addr;
        r_mem_wdata  <= dm_wdata;
      end
    end
  end

  // Responses are suppressed while rst is high, so an in-flight reply is dropped.
  assign w_if_done = !rst && (r_state == IF_BUSY) && w_done;
  assign w_dm_done = !rst && (r_state == DM_BUSY) && w_done;
  assign w_rdata   = mem_data_valid ? mem_rdata : 32'h0;

  assign if_data_valid = w_if_done;
  assign if_rdata      = w_if_done ? w_rdata : 32'h0;
  assign dm_data_valid = w_dm_done;
  assign dm_rdata      = w_dm_done ? w_rdata : 32'h0;
  assign if_stall      = if_request & ~w_if_done;
  assign dm_stall      = dm_request & ~w_dm_done;

  assign mem_request = w_busy;
  assign mem_we_re   = r_mem_we_re;
  assign mem_mask    = r_mem_mask;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;

endmodule
